// File: rtl/mips_pkg.sv
// Shared encodings for the 1-to-4 result steering buffer: destination selects,
// slot states and default widths.
package mips_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CNT_W_DEF = 16;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux4_slot.sv
// One-entry output register slot: loads on demand, drains on ready, and
// clears on flush while keeping its last data word visible.
module demux4_slot
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_state_t state;

    // Load wins over drain so a full slot can be drained and refilled in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            data  <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (load) begin
            state <= FULL;
            data  <= load_data;
        end else if (state == FULL && ready) begin
            state <= EMPTY;
        end
    end

    assign valid = (state == FULL);

endmodule

// File: rtl/demux4_router.sv
// 1-to-4 steering buffer with a one-entry slot per sink.
// Optional per-sink transfer counters are enabled by defining DEMUX4_STATS_EN.
module demux4_router
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       ctrl,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data_a,
    output logic [WIDTH-1:0] out_data_b,
    output logic [WIDTH-1:0] out_data_c,
    output logic [WIDTH-1:0] out_data_d
`ifdef DEMUX4_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
`endif
);

    logic [3:0]       dest;
    logic             accept;
    logic [WIDTH-1:0] slot_data [4];

    always_comb begin
        dest = 4'b0000;
        case (ctrl)
            SEL_A:   dest[0] = 1'b1;
            SEL_B:   dest[1] = 1'b1;
            SEL_C:   dest[2] = 1'b1;
            SEL_D:   dest[3] = 1'b1;
            default: dest = 4'b0000;
        endcase
    end

    // Only the addressed slot can stall the input; rst_n keeps it low during reset.
    assign in_ready = rst_n & ~flush & (~out_valid[ctrl] | out_ready[ctrl]);
    assign accept   = in_valid & in_ready;

    for (genvar g = 0; g < 4; g++) begin : g_slot
        demux4_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .load      (accept & dest[g]),
            .load_data (in_data),
            .ready     (out_ready[g]),
            .valid     (out_valid[g]),
            .data      (slot_data[g])
        );
    end

    assign out_data_a = slot_data[0];
    assign out_data_b = slot_data[1];
    assign out_data_c = slot_data[2];
    assign out_data_d = slot_data[3];

`ifdef DEMUX4_STATS_EN
    logic [CNT_W-1:0] cnt [4];

    // Counts completed output handshakes; flush does not touch them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    assign cnt_a = cnt[0];
    assign cnt_b = cnt[1];
    assign cnt_c = cnt[2];
    assign cnt_d = cnt[3];
`endif

endmodule

// File: tb/tb_demux4_router.sv
// Bench for demux4_router: directed scenarios plus random traffic checked
// against a per-slot occupancy model (counters checked when DEMUX4_STATS_EN).
module tb_demux4_router;

`ifdef DEMUX4_STATS_EN
    localparam int CNT_MOD = 16;
    localparam int unsigned TB_CNT_W = 4;
`else
    localparam int CNT_MOD = 65536;
    localparam int unsigned TB_CNT_W = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  ctrl;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data_a, out_data_b, out_data_c, out_data_d;
    logic [31:0] od [4];
`ifdef DEMUX4_STATS_EN
    logic [3:0]  cnt_a, cnt_b, cnt_c, cnt_d;
    logic [3:0]  cn [4];
`endif

    demux4_router #(.WIDTH(32), .CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .ctrl       (ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data_a (out_data_a),
        .out_data_b (out_data_b),
        .out_data_c (out_data_c),
        .out_data_d (out_data_d)
`ifdef DEMUX4_STATS_EN
        ,
        .cnt_a      (cnt_a),
        .cnt_b      (cnt_b),
        .cnt_c      (cnt_c),
        .cnt_d      (cnt_d)
`endif
    );

    always #5 clk = ~clk;

    assign od[0] = out_data_a;
    assign od[1] = out_data_b;
    assign od[2] = out_data_c;
    assign od[3] = out_data_d;
`ifdef DEMUX4_STATS_EN
    assign cn[0] = cnt_a;
    assign cn[1] = cnt_b;
    assign cn[2] = cnt_c;
    assign cn[3] = cnt_d;
`endif

    // Reference model: which sinks hold an undelivered word, what each sink shows, and transfer counts.
    bit          m_full [4];
    logic [31:0] m_data [4];
    int          m_cnt  [4];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = 32'h0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] ev;
        for (int i = 0; i < 4; i++) ev[i] = m_full[i];
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s out_data[%0d]", tag, i), od[i], m_data[i]);
`ifdef DEMUX4_STATS_EN
            chk($sformatf("%s cnt[%0d]", tag, i), 32'(cn[i]), 32'(m_cnt[i]));
`endif
        end
    endtask

    // One clock: drive at negedge, check against the model, then advance the model across the edge.
    task automatic cycle(input bit v, input logic [1:0] c, input logic [31:0] d,
                         input logic [3:0] ordy, input bit fl);
        bit rdy, acc, xfer;
        @(negedge clk);
        in_valid = v; ctrl = c; in_data = d; out_ready = ordy; flush = fl;
        #1;
        rdy = !fl && (!m_full[c] || ordy[c]);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        check_outputs("cyc");
        acc = v && rdy;
        for (int i = 0; i < 4; i++) begin
            xfer = m_full[i] && ordy[i];
            if (xfer) m_cnt[i] = (m_cnt[i] + 1) % CNT_MOD;
            if (fl) m_full[i] = 1'b0;
            else if (acc && int'(c) == i) begin
                m_full[i] = 1'b1;
                m_data[i] = d;
            end else if (xfer) m_full[i] = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 2'b00, 32'h0, 4'b1111, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 4'b0000;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0;
        ctrl = 2'b00; out_ready = 4'b0000;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'h0);
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Route to c, then drain
        cycle(1'b1, 2'b10, 32'hDEADBEEF, 4'b1111, 1'b0);
        #1;
        chk("route out_valid", 32'(out_valid), 32'h4);
        chk("route out_data_c", out_data_c, 32'hDEADBEEF);
        idle_cycle();
        #1;
        chk("route drained", 32'(out_valid), 32'h0);

        // Backpressure on a does not block d
        cycle(1'b1, 2'b00, 32'hA5A5_0001, 4'b0000, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; ctrl = 2'b00; in_data = 32'hBAD0_BAD0; out_ready = 4'b0000;
        #1;
        chk("bp in_ready a", 32'(in_ready), 32'h0);
        ctrl = 2'b11;
        #1;
        chk("bp in_ready d", 32'(in_ready), 32'h1);
        in_valid = 1'b0;
        cycle(1'b1, 2'b11, 32'h0D0D_0D0D, 4'b0000, 1'b0);
        #1;
        chk("bp out_valid", 32'(out_valid), 32'h9);
        chk("bp a held", out_data_a, 32'hA5A5_0001);
        chk("bp d data", out_data_d, 32'h0D0D_0D0D);
        idle_cycle();

        // Drain + refill on b
        cycle(1'b1, 2'b01, 32'hBBBB_BBBB, 4'b0000, 1'b0);
        cycle(1'b1, 2'b01, 32'h0000_0001, 4'b0010, 1'b0);
        #1;
        chk("refill out_valid b", 32'(out_valid[1]), 32'h1);
        chk("refill out_data_b", out_data_b, 32'h1);
        idle_cycle();

        // Flush beats a simultaneous accept
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 32'hF000_0000 + 32'(i), 4'b0000, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; ctrl = 2'b10; in_data = 32'h1234_5678; out_ready = 4'b0000;
        #1;
        chk("flush in_ready", 32'(in_ready), 32'h0);
        flush = 1'b0; in_valid = 1'b0;
        cycle(1'b1, 2'b10, 32'h1234_5678, 4'b0000, 1'b1);
        #1;
        chk("flush out_valid", 32'(out_valid), 32'h0);
        chk("flush data retained", out_data_c, 32'hF000_0002);

        // Reset mid-run with b full
        cycle(1'b1, 2'b01, 32'h5555_AAAA, 4'b0000, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 4'b0010;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midreset in_ready", 32'(in_ready), 32'h0);
        check_outputs("midreset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)), $urandom_range(0, 15) == 0);
        end

`ifdef DEMUX4_STATS_EN
        // Counter wrap after 17 transfers on a
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, 2'b00, 32'(i), 4'b0001, 1'b0);
        cycle(1'b0, 2'b00, 32'h0, 4'b0001, 1'b0);
        #1;
        chk("wrap cnt_a", 32'(cnt_a), 32'h1);
        chk("wrap cnt_b", 32'(cnt_b), 32'h0);
        chk("wrap cnt_c", 32'(cnt_c), 32'h0);
        chk("wrap cnt_d", 32'(cnt_d), 32'h0);
`endif

        idle_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
